anf_fl_tex_block_fetch: RTL and testbench
=========================================

// Module: anf_fl_tex_block_fetch
// PURPOSE
//  Upstream feeder for the ETC2 block decoder. Accepts one texel request (u, v, texture descriptor).
//  Computes the address of the 4x4 block that holds the texel and reads that 128-bit block from memory.
//  A single-entry block cache absorbs repeated hits. Presents block data, format and in-block
//  texel offsets to the decoder.
// PARAMETERS
//  ADDR_W   32  byte-address width of memory and texture base
//  COORD_W  12  texel coordinate width (u, v)
//  LOG2_W   4   width of the log2 texture dimension fields
// PORTS
//  clk            in   1        sole clock, all state on rising edge
//  rst            in   1        synchronous, active-high reset
//  req_valid      in   1        texel request valid
//  req_ready      out  1        request accepted when valid&&ready
//  req_u          in   COORD_W  texel x
//  req_v          in   COORD_W  texel y
//  req_base       in   ADDR_W   texture base byte address, 16-byte aligned
//  req_wlog2      in   LOG2_W   log2 texture width in texels, >=2
//  req_hlog2      in   LOG2_W   log2 texture height in texels, >=2
//  req_format     in   5        format code, passed through
//  invalidate     in   1        drop cached block
//  mem_req_valid  out  1        memory read request
//  mem_req_ready  in   1        memory accepts request
//  mem_addr       out  ADDR_W   block byte address
//  mem_resp_valid in   1        read data valid (one beat, in order, one outstanding max)
//  mem_resp_data  in   128      block data
//  out_valid      out  1        decoder-side data valid
//  out_ready      in   1        decoder-side accept
//  out_data       out  128      block to decoder
//  out_format     out  5        format of request
//  out_u_texel    out  2        u[1:0] after wrap
//  out_v_texel    out  2        v[1:0] after wrap
// BEHAVIOUR
//  - Wrap (repeat): u' = u & ((1<<wlog2)-1), v' = v & ((1<<hlog2)-1).
//  - Address: bx = u'>>2, by = v'>>2.
//    addr = base + (((by << (wlog2-2)) + bx) << 4), computed modulo 2^ADDR_W.
//  - Cache: tag_valid plus tag_addr[ADDR_W] plus blk[128]. Hit = tag_valid && tag_addr==addr.
//  - States:
//    - IDLE: req_ready=1. On accept, latch format, u'[1:0], v'[1:0] and addr.
//      Hit -> OUT. Miss -> MREQ.
//    - MREQ: mem_req_valid=1, mem_addr held stable until mem_req_ready, then -> MWAIT.
//    - MWAIT: on mem_resp_valid, load blk and tag_addr, set tag_valid, -> OUT.
//    - OUT: out_valid=1, all out_* held stable until out_ready; on out_ready -> IDLE.
//  - req_ready=0 in every state other than IDLE; no accept in the cycle OUT retires.
//  - Latency from accept at cycle N:
//    - hit: out_valid at N+1.
//    - miss: mem_req_valid at N+1; out_valid one cycle after the mem_resp_valid cycle.
//  - Throughput: one request per 2 cycles at best (hit, out_ready tied 1).
//  - invalidate clears tag_valid in any state, with priority over a same-cycle fill.
//    - In IDLE with a same-cycle accept, the lookup treats the entry as invalid (miss).
//    - In MWAIT, the returning block is still delivered on out_*; tag_valid stays 0.
//  - mem_resp_valid outside MWAIT is ignored (e.g. a stale response after reset).
//  - Reset values:
//    - state=IDLE, tag_valid=0.
//    - mem_req_valid=0, out_valid=0, req_ready=1 from the first post-reset cycle.
//    - mem_addr, out_data, out_format, out_u_texel, out_v_texel all 0.
//  - Reset mid-operation abandons the transaction; the memory side must also be reset or drained.
// STRUCTURE
//  - Package anf_fl_tex_pkg:
//    - TEX_BLOCK_BYTES=16, TEX_BLOCK_DIM=4
//    - fetch state enum {IDLE, MREQ, MWAIT, OUT}
//    - format code constants shared with the decoder
//  - Sub-module anf_fl_tex_block_addr: combinational wrap and address generation
//    (u, v, base, wlog2, hlog2 -> addr, u_texel, v_texel).
//  - FSM, tag and output registers live in this module.
// TESTING
//  1. Miss: base=0x1000, w=h=16 (log2 4), u=5, v=9, memory returns 0xA5..A5.
//     Required: mem_addr=0x1000+((2*4+1)<<4)=0x1090, out_data=0xA5..A5, out_u_texel=1, out_v_texel=1.
//  2. Hit: repeat (u=6, v=10) after test 1.
//     Required: no mem_req_valid, out_valid at N+1, same data, out_u_texel=2, out_v_texel=2.
//  3. Wrap: u=21, v=3, w=h=16.
//     Required: u'=5, mem_addr=0x1000+(1<<4)=0x1010.
//  4. Backpressure: out_ready=0 for 5 cycles in OUT.
//     Required: out_* stable, req_ready=0, then retire on the first out_ready=1.
//  5. Invalidate during MWAIT:
//     Required: block delivered, then the identical request misses and a new mem_req_valid appears.
//  6. Reset asserted in MWAIT, then a stale mem_resp_valid arrives.
//     Required: outputs at reset values, out_valid stays 0, first post-reset request is a miss.

Source files
------------

// File: rtl/anf_fl_tex_pkg.sv
// anf_fl_tex_pkg: shared block geometry, fetch states and format codes for the texture path
package anf_fl_tex_pkg;
  localparam int TEX_BLOCK_BYTES = 16;
  localparam int TEX_BLOCK_DIM = 4;
  localparam int TEX_BLOCK_SHIFT = $clog2(TEX_BLOCK_BYTES);
  localparam int TEX_DIM_SHIFT = $clog2(TEX_BLOCK_DIM);
  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, OUT} fetch_state_e;
  localparam logic [4:0] FMT_ETC2_RGB8 = 5'd0;
  localparam logic [4:0] FMT_ETC2_RGB8A1 = 5'd1;
  localparam logic [4:0] FMT_ETC2_RGBA8 = 5'd2;
  localparam logic [4:0] FMT_EAC_R11 = 5'd3;
  localparam logic [4:0] FMT_EAC_RG11 = 5'd4;
endpackage

// File: rtl/anf_fl_tex_block_addr.sv
// anf_fl_tex_block_addr: wraps texel coordinates and forms the 4x4 block byte address
module anf_fl_tex_block_addr
  import anf_fl_tex_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int COORD_W = 12,
  parameter int LOG2_W = 4
) (
  input  logic [COORD_W-1:0] u,
  input  logic [COORD_W-1:0] v,
  input  logic [ADDR_W-1:0]  base,
  input  logic [LOG2_W-1:0]  wlog2,
  input  logic [LOG2_W-1:0]  hlog2,
  output logic [ADDR_W-1:0]  addr,
  output logic [1:0]         u_texel,
  output logic [1:0]         v_texel
);
  logic [COORD_W-1:0] uw, vw;
  logic [ADDR_W-1:0] bx, by;
  // a shift of the all-ones word by >= COORD_W yields an all-ones mask
  assign uw = u & ~({COORD_W{1'b1}} << wlog2);
  assign vw = v & ~({COORD_W{1'b1}} << hlog2);
  assign bx = ADDR_W'(uw >> TEX_DIM_SHIFT);
  assign by = ADDR_W'(vw >> TEX_DIM_SHIFT);
  assign addr = base + (((by << (wlog2 - LOG2_W'(TEX_DIM_SHIFT))) + bx) << TEX_BLOCK_SHIFT);
  assign u_texel = uw[1:0];
  assign v_texel = vw[1:0];
endmodule

// File: rtl/anf_fl_tex_block_fetch.sv
// anf_fl_tex_block_fetch: fetches the 128-bit ETC2 block for a texel through a one-entry cache
module anf_fl_tex_block_fetch
  import anf_fl_tex_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int COORD_W = 12,
  parameter int LOG2_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_u,
  input  logic [COORD_W-1:0] req_v,
  input  logic [ADDR_W-1:0]  req_base,
  input  logic [LOG2_W-1:0]  req_wlog2,
  input  logic [LOG2_W-1:0]  req_hlog2,
  input  logic [4:0]         req_format,
  input  logic               invalidate,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_resp_valid,
  input  logic [127:0]       mem_resp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic [4:0]         out_format,
  output logic [1:0]         out_u_texel,
  output logic [1:0]         out_v_texel
);
  fetch_state_e state;
  logic tag_valid, hit;
  logic [ADDR_W-1:0] tag_addr, addr;
  logic [127:0] blk;
  logic [1:0] u_texel, v_texel;
  anf_fl_tex_block_addr #(.ADDR_W(ADDR_W), .COORD_W(COORD_W), .LOG2_W(LOG2_W)) u_addr (
    .u(req_u), .v(req_v), .base(req_base), .wlog2(req_wlog2), .hlog2(req_hlog2),
    .addr(addr), .u_texel(u_texel), .v_texel(v_texel)
  );
  // a same-cycle invalidate must already make the lookup miss
  assign hit = tag_valid && !invalidate && tag_addr == addr;
  assign req_ready = state == IDLE;
  assign mem_req_valid = state == MREQ;
  assign out_valid = state == OUT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tag_valid <= 1'b0;
      tag_addr <= '0;
      blk <= '0;
      mem_addr <= '0;
      out_data <= '0;
      out_format <= '0;
      out_u_texel <= '0;
      out_v_texel <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          mem_addr <= addr;
          out_format <= req_format;
          out_u_texel <= u_texel;
          out_v_texel <= v_texel;
          out_data <= blk;
          state <= hit ? OUT : MREQ;
        end
        MREQ: if (mem_req_ready) state <= MWAIT;
        MWAIT: if (mem_resp_valid) begin
          blk <= mem_resp_data;
          tag_addr <= mem_addr;
          tag_valid <= 1'b1;
          out_data <= mem_resp_data;
          state <= OUT;
        end
        OUT: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (invalidate) tag_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_anf_fl_tex_block_fetch.sv
// tb_anf_fl_tex_block_fetch: table-driven requests with a scoreboard of expected decoder-side beats
module tb_anf_fl_tex_block_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [11:0] req_u = '0, req_v = '0;
  logic [31:0] req_base = '0;
  logic [3:0] req_wlog2 = 4'd2, req_hlog2 = 4'd2;
  logic [4:0] req_format = '0;
  logic invalidate = 1'b0;
  logic mem_req_valid;
  logic mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [127:0] out_data;
  logic [4:0] out_format;
  logic [1:0] out_u_texel, out_v_texel;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [11:0] u, v;
    logic [31:0] base;
    logic [3:0] wl, hl;
    logic [4:0] fmt;
    logic [127:0] mdata;
    bit miss;
    logic [31:0] addr;
    logic [1:0] ut, vt;
    int stall;
    int inv;
  } vec_t;
  typedef struct {
    logic [127:0] data;
    logic [4:0] fmt;
    logic [1:0] ut, vt;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[10];

  anf_fl_tex_block_fetch dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_u(req_u), .req_v(req_v), .req_base(req_base), .req_wlog2(req_wlog2),
    .req_hlog2(req_hlog2), .req_format(req_format), .invalidate(invalidate),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_format(out_format), .out_u_texel(out_u_texel), .out_v_texel(out_v_texel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_format"}, out_format, 0);
    chk({tag, "_out_u"}, out_u_texel, 0);
    chk({tag, "_out_v"}, out_v_texel, 0);
  endtask

  task automatic run(input vec_t t);
    exp_t e;
    logic [127:0] snap;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_u = t.u;
    req_v = t.v;
    req_base = t.base;
    req_wlog2 = t.wl;
    req_hlog2 = t.hl;
    req_format = t.fmt;
    invalidate = t.inv == 1;
    sb.push_back('{t.mdata, t.fmt, t.ut, t.vt});
    @(negedge clk);
    req_valid = 1'b0;
    invalidate = 1'b0;
    req_u = ~t.u;
    req_v = ~t.v;
    req_base = ~t.base;
    req_format = ~t.fmt;
    chk("mem_req_valid_n1", mem_req_valid, t.miss);
    chk("out_valid_n1", out_valid, !t.miss);
    chk("req_ready_busy", req_ready, 0);
    if (t.miss) begin
      chk("mem_addr", mem_addr, t.addr);
      @(negedge clk);
      chk("mem_addr_hold", mem_addr, t.addr);
      chk("mem_req_valid_hold", mem_req_valid, 1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("mem_req_drop", mem_req_valid, 0);
      chk("out_valid_wait", out_valid, 0);
      mem_resp_valid = 1'b1;
      mem_resp_data = t.mdata;
      invalidate = t.inv == 2;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data = '0;
      invalidate = 1'b0;
      chk("out_valid_fill", out_valid, 1);
    end
    snap = out_data;
    for (int i = 0; i < t.stall; i++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_data", out_data, snap);
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, e.data);
      chk("out_format", out_format, e.fmt);
      chk("out_u_texel", out_u_texel, e.ut);
      chk("out_v_texel", out_v_texel, e.vt);
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("retire_out_valid", out_valid, 0);
    chk("retire_req_ready", req_ready, 1);
  endtask

  initial begin
    vecs[0] = '{12'd5, 12'd9, 32'h1000, 4'd4, 4'd4, 5'd3, {16{8'hA5}}, 1'b1, 32'h1090, 2'd1, 2'd1, 0, 0};
    vecs[1] = '{12'd6, 12'd10, 32'h1000, 4'd4, 4'd4, 5'd4, {16{8'hA5}}, 1'b0, 32'h1090, 2'd2, 2'd2, 0, 0};
    vecs[2] = '{12'd21, 12'd3, 32'h1000, 4'd4, 4'd4, 5'd5, 128'h0123456789abcdef_fedcba9876543210, 1'b1, 32'h1010, 2'd1, 2'd3, 5, 0};
    vecs[3] = '{12'd5, 12'd9, 32'h1000, 4'd4, 4'd4, 5'd3, {16{8'hA5}}, 1'b1, 32'h1090, 2'd1, 2'd1, 0, 2};
    vecs[4] = '{12'd5, 12'd9, 32'h1000, 4'd4, 4'd4, 5'd3, {16{8'hA5}}, 1'b1, 32'h1090, 2'd1, 2'd1, 0, 0};
    vecs[5] = '{12'd7, 12'd8, 32'h1000, 4'd4, 4'd4, 5'd6, {16{8'hA5}}, 1'b0, 32'h1090, 2'd3, 2'd0, 0, 0};
    vecs[6] = '{12'd7, 12'd8, 32'h1000, 4'd4, 4'd4, 5'd6, {16{8'h5A}}, 1'b1, 32'h1090, 2'd3, 2'd0, 1, 1};
    vecs[7] = '{12'd130, 12'd13, 32'h2000_0000, 4'd6, 4'd3, 5'd7, 128'hdeadbeef_00000000_11111111_22222222, 1'b1, 32'h2000_0100, 2'd2, 2'd1, 0, 0};
    vecs[8] = '{12'd4, 12'd0, 32'hFFFF_FFF0, 4'd4, 4'd4, 5'd8, {4{32'hcafef00d}}, 1'b1, 32'h0000_0000, 2'd0, 2'd0, 0, 0};
    vecs[9] = '{12'hFFF, 12'hFFF, 32'h0, 4'd12, 4'd12, 5'd31, {4{32'h13579bdf}}, 1'b1, 32'h00FF_FFF0, 2'd3, 2'd3, 0, 0};

    repeat (2) @(negedge clk);
    chk_reset_vals("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("post_reset");
    foreach (vecs[k]) run(vecs[k]);

    // reset lands while a miss is waiting on memory
    @(negedge clk);
    req_valid = 1'b1;
    req_u = 12'd0;
    req_v = 12'd0;
    req_base = 32'h0;
    req_wlog2 = 4'd12;
    req_hlog2 = 4'd12;
    req_format = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_seq_mem_req", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rst_seq_in_mwait", mem_req_valid | out_valid | req_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_reset");
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = {16{8'h77}};
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    chk("stale_out_valid", out_valid, 0);
    chk("stale_req_ready", req_ready, 1);
    chk("stale_out_data", out_data, 0);
    @(negedge clk);
    chk("stale_out_valid2", out_valid, 0);
    run(vecs[9]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
